// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
//   Shared board definitions for the minesweeper datapath.
//   - level_t : difficulty selector (none / easy / medium / hard)
//   - state_t : state encoding of the mine-number generator
//   - SIDE_*  : board side lengths per level
//   - size_of : board side for a level (0 for LVL_NONE)
//   - last_idx: highest row/col index for a level, as a 4-bit counter value
// ---------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    LVL_NONE   = 2'd0,
    LVL_EASY   = 2'd1,
    LVL_MEDIUM = 2'd2,
    LVL_HARD   = 2'd3
  } level_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned SIDE_EASY   = 8;
  localparam int unsigned SIDE_MEDIUM = 10;
  localparam int unsigned SIDE_HARD   = 16;

  function automatic logic [4:0] size_of(input level_t lvl);
    logic [4:0] side;
    case (lvl)
      LVL_EASY:   side = 5'(SIDE_EASY);
      LVL_MEDIUM: side = 5'(SIDE_MEDIUM);
      LVL_HARD:   side = 5'(SIDE_HARD);
      default:    side = 5'd0;
    endcase
    return side;
  endfunction

  // LVL_NONE never reaches the scan, so its (wrapped) value is irrelevant.
  function automatic logic [3:0] last_idx(input level_t lvl);
    logic [4:0] idx;
    idx = size_of(lvl) - 5'd1;
    return idx[3:0];
  endfunction

endpackage

// File: rtl/mine_num_gen_neighbour_count.sv
// ---------------------------------------------------------------------------
// neighbour_count
//   Combinational count of mines among the 8 neighbours of (row, col) on a
//   size x size board held in the upper-left corner of mine_map.
//   Ports:
//     mine_map  in  [row][col] mine bits, 1 = mine
//     row, col  in  field being evaluated
//     size      in  board side (8/10/16); bits beyond it are ignored
//     count     out number of in-board neighbour mines, 0..8
// ---------------------------------------------------------------------------
module neighbour_count #(
  parameter int unsigned MAX_SIZE = 16
) (
  input  logic [MAX_SIZE-1:0][MAX_SIZE-1:0] mine_map,
  input  logic [3:0]                        row,
  input  logic [3:0]                        col,
  input  logic [4:0]                        size,
  output logic [3:0]                        count
);

  logic [4:0] rr;
  logic [4:0] cc;

  // Neighbour coordinates are formed in 5 bits: row 0 minus one wraps to 31,
  // which the "< size" test then rejects exactly like a coordinate past the
  // far edge, so one unsigned compare covers both board boundaries.
  always_comb begin
    count = '0;
    rr    = '0;
    cc    = '0;
    for (int unsigned dr = 0; dr < 3; dr++) begin
      for (int unsigned dc = 0; dc < 3; dc++) begin
        rr = 5'(row) + 5'(dr) - 5'd1;
        cc = 5'(col) + 5'(dc) - 5'd1;
        if (!(dr == 1 && dc == 1) && (rr < size) && (cc < size)) begin
          if (mine_map[rr[3:0]][cc[3:0]]) begin
            count = count + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/mine_num_gen.sv
// ---------------------------------------------------------------------------
// mine_num_gen
//   Writer side of the per-field mine-number arrays. A start pulse scans the
//   selected board row-major, one field per clock, writing each field's
//   saturated neighbour-mine count into that level's array. The arrays of
//   the other levels are untouched and all arrays hold between scans.
//   Ports:
//     clk             in   system clock, rising edge
//     rst             in   asynchronous active-low reset
//     level           in   1=easy 2=medium 3=hard 0=none, sampled on start
//     start           in   one-cycle pulse, begins a scan when idle
//     mine_map        in   [row][col] mine bits, stable while busy
//     num_arr_easy    out  8x8 neighbour counts
//     num_arr_medium  out  10x10 neighbour counts
//     num_arr_hard    out  16x16 neighbour counts
//     busy            out  high from the cycle after an accepted start until done
//     done            out  one-cycle pulse, scan complete
// ---------------------------------------------------------------------------
module mine_num_gen
  import game_pkg::*;
#(
  parameter int unsigned NUM_W    = 3,
  parameter int unsigned MAX_SIZE = 16
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [1:0]                                     level,
  input  logic                                           start,
  input  logic [MAX_SIZE-1:0][MAX_SIZE-1:0]              mine_map,
  output logic [SIDE_EASY-1:0][SIDE_EASY-1:0][NUM_W-1:0]     num_arr_easy,
  output logic [SIDE_MEDIUM-1:0][SIDE_MEDIUM-1:0][NUM_W-1:0] num_arr_medium,
  output logic [SIDE_HARD-1:0][SIDE_HARD-1:0][NUM_W-1:0]     num_arr_hard,
  output logic                                           busy,
  output logic                                           done
);

  localparam logic [3:0] CNT_MAX = 4'((1 << NUM_W) - 1);

  state_t     state;
  level_t     lvl_q;
  logic [3:0] row;
  logic [3:0] col;

  logic [4:0]       board_size;
  logic [3:0]       last;
  logic [3:0]       nb_count;
  logic [NUM_W-1:0] cnt_sat;

  // Board geometry always comes from the level latched at start, so a
  // changing level input cannot disturb a scan in flight.
  assign board_size = size_of(lvl_q);
  assign last       = last_idx(lvl_q);

  neighbour_count #(
    .MAX_SIZE (MAX_SIZE)
  ) u_neighbour_count (
    .mine_map (mine_map),
    .row      (row),
    .col      (col),
    .size     (board_size),
    .count    (nb_count)
  );

  always_comb begin
    cnt_sat = '0;
    if (nb_count > CNT_MAX) begin
      cnt_sat = CNT_MAX[NUM_W-1:0];
    end else begin
      cnt_sat = nb_count[NUM_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      lvl_q          <= LVL_NONE;
      row            <= '0;
      col            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      num_arr_easy   <= '0;
      num_arr_medium <= '0;
      num_arr_hard   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            lvl_q <= level_t'(level);
            busy  <= 1'b1;
            state <= ST_CLEAR;
          end
        end

        ST_CLEAR: begin
          row <= '0;
          col <= '0;
          case (lvl_q)
            LVL_EASY:   num_arr_easy   <= '0;
            LVL_MEDIUM: num_arr_medium <= '0;
            LVL_HARD:   num_arr_hard   <= '0;
            default:    ;
          endcase
          state <= (lvl_q == LVL_NONE) ? ST_DONE : ST_SCAN;
        end

        ST_SCAN: begin
          case (lvl_q)
            LVL_EASY:   num_arr_easy[row[2:0]][col[2:0]] <= cnt_sat;
            LVL_MEDIUM: num_arr_medium[row][col]         <= cnt_sat;
            LVL_HARD:   num_arr_hard[row][col]           <= cnt_sat;
            default:    ;
          endcase
          if (col == last) begin
            col <= '0;
            if (row == last) begin
              row   <= '0;
              state <= ST_DONE;
            end else begin
              row <= row + 4'd1;
            end
          end else begin
            col <= col + 4'd1;
          end
        end

        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mine_num_gen.sv
// ---------------------------------------------------------------------------
// tb_mine_num_gen
//   Directed bench for mine_num_gen. A reference model holds the expected
//   arrays (computed from the mine map by window counting) and the expected
//   busy/done timeline (start edge + N*N + 2); one negedge process compares
//   the DUT against it every cycle. Hand-computed literals pin the model.
// ---------------------------------------------------------------------------
module tb_mine_num_gen;

  logic              clk   = 1'b0;
  logic              rst   = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        level = 2'd0;
  logic [15:0][15:0] mm    = '0;

  logic [7:0][7:0][2:0]   num_arr_easy;
  logic [9:0][9:0][2:0]   num_arr_medium;
  logic [15:0][15:0][2:0] num_arr_hard;
  logic                   busy;
  logic                   done;

  mine_num_gen #(
    .NUM_W    (3),
    .MAX_SIZE (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .level          (level),
    .start          (start),
    .mine_map       (mm),
    .num_arr_easy   (num_arr_easy),
    .num_arr_medium (num_arr_medium),
    .num_arr_hard   (num_arr_hard),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  // cyc equals the number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0][7:0][2:0]   exp_easy   = '0;
  logic [9:0][9:0][2:0]   exp_medium = '0;
  logic [15:0][15:0][2:0] exp_hard   = '0;
  bit                     active     = 1'b0;
  int                     k_edge     = 0;
  int                     done_cyc   = 0;

  task automatic chk(input string name, input logic [767:0] act, input logic [767:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic int side(input logic [1:0] lv);
    case (lv)
      2'd1:    return 8;
      2'd2:    return 10;
      2'd3:    return 16;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] ref_count(input int r, input int c, input int n);
    int tot = 0;
    for (int rr = r - 1; rr <= r + 1; rr++)
      for (int cc = c - 1; cc <= c + 1; cc++)
        if (rr >= 0 && rr < n && cc >= 0 && cc < n && !(rr == r && cc == c))
          if (mm[rr[3:0]][cc[3:0]]) tot++;
    return (tot > 7) ? 3'd7 : 3'(tot);
  endfunction

  task automatic model_scan(input logic [1:0] lv);
    int n = side(lv);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        case (lv)
          2'd1: exp_easy[r[2:0]][c[2:0]]   = ref_count(r, c, n);
          2'd2: exp_medium[r[3:0]][c[3:0]] = ref_count(r, c, n);
          2'd3: exp_hard[r[3:0]][c[3:0]]   = ref_count(r, c, n);
          default: ;
        endcase
  endtask

  // Start is presented for exactly one rising edge; it is only accepted
  // when that edge comes after the previous operation's done cycle.
  task automatic do_start(input logic [1:0] lv);
    @(posedge clk); #1;
    level = lv;
    start = 1'b1;
    if (!active || cyc + 1 > done_cyc) begin
      k_edge   = cyc + 1;
      done_cyc = k_edge + side(lv) * side(lv) + 2;
      active   = 1'b1;
      model_scan(lv);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input int exp_lat, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk({nm, "_seen"}, 768'(seen), 768'(1));
    if (seen) chk({nm, "_latency"}, 768'(cyc - k_edge), 768'(exp_lat));
  endtask

  task automatic mid_reset();
    @(posedge clk); #3;
    rst        = 1'b0;
    active     = 1'b0;
    exp_easy   = '0;
    exp_medium = '0;
    exp_hard   = '0;
    #1;
    chk("rst_busy", 768'(busy), 768'(0));
    chk("rst_done", 768'(done), 768'(0));
    chk("rst_easy", 768'(num_arr_easy), 768'(0));
    chk("rst_medium", 768'(num_arr_medium), 768'(0));
    chk("rst_hard", 768'(num_arr_hard), 768'(0));
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
  endtask

  task automatic set_ring();
    mm = '0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (!(dr == 0 && dc == 0)) mm[5 + dr][5 + dc] = 1'b1;
  endtask

  // Arrays are skipped from the cycle the start is presented (the model
  // already holds the finished image) until the done cycle.
  always @(negedge clk) begin
    bit in_scan;
    bit arr_busy;
    in_scan  = active && cyc >= k_edge && cyc < done_cyc;
    arr_busy = active && cyc + 1 >= k_edge && cyc < done_cyc;
    chk("busy", 768'(busy), 768'(in_scan));
    chk("done", 768'(done), 768'(active && cyc == done_cyc));
    if (!arr_busy) begin
      chk("arr_easy", 768'(num_arr_easy), 768'(exp_easy));
      chk("arr_medium", 768'(num_arr_medium), 768'(exp_medium));
      chk("arr_hard", 768'(num_arr_hard), 768'(exp_hard));
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #3;
    chk("init_busy", 768'(busy), 768'(0));
    chk("init_done", 768'(done), 768'(0));
    chk("init_hard", 768'(num_arr_hard), 768'(0));
    rst = 1'b1;

    // Easy corner
    mm = '0;
    mm[0][1] = 1'b1;
    mm[1][0] = 1'b1;
    mm[1][1] = 1'b1;
    do_start(2'd1);
    wait_done(100, 66, "easy");
    chk("model_easy00", 768'(exp_easy[0][0]), 768'(3));
    chk("model_easy22", 768'(exp_easy[2][2]), 768'(1));
    chk("easy00", 768'(num_arr_easy[0][0]), 768'(3));
    chk("easy22", 768'(num_arr_easy[2][2]), 768'(1));
    chk("easy77", 768'(num_arr_easy[7][7]), 768'(0));

    // Full neighbourhood with an ignored mid-scan start
    @(negedge clk); #1;
    set_ring();
    do_start(2'd3);
    repeat (30) @(posedge clk);
    do_start(2'd2);
    wait_done(400, 258, "hard");
    chk("model_hard55", 768'(exp_hard[5][5]), 768'(7));
    chk("hard55", 768'(num_arr_hard[5][5]), 768'(7));
    chk("hard44", 768'(num_arr_hard[4][4]), 768'(2));

    // Retention of the hard array across an easy scan
    @(negedge clk); #1;
    mm = '0;
    mm[3][3] = 1'b1;
    do_start(2'd1);
    wait_done(100, 66, "easy2");
    chk("hard_kept55", 768'(num_arr_hard[5][5]), 768'(7));
    chk("easy2_22", 768'(num_arr_easy[2][2]), 768'(1));
    chk("easy2_33", 768'(num_arr_easy[3][3]), 768'(0));

    // Edge masking on the medium board
    @(negedge clk); #1;
    mm = '0;
    mm[12][3] = 1'b1;
    do_start(2'd2);
    wait_done(200, 102, "med");
    chk("med_all0", 768'(num_arr_medium), 768'(0));
    @(negedge clk); #1;
    mm[9][9] = 1'b1;
    do_start(2'd2);
    wait_done(200, 102, "med2");
    chk("med88", 768'(num_arr_medium[8][8]), 768'(1));
    chk("med98", 768'(num_arr_medium[9][8]), 768'(1));
    chk("med99", 768'(num_arr_medium[9][9]), 768'(0));

    // Level 0: done after 2 cycles, nothing written
    do_start(2'd0);
    wait_done(10, 2, "lvl0");
    chk("lvl0_easy22", 768'(num_arr_easy[2][2]), 768'(1));

    // Reset around cycle 50 of a hard scan, then a clean restart
    @(negedge clk); #1;
    set_ring();
    do_start(2'd3);
    repeat (48) @(posedge clk);
    mid_reset();
    repeat (300) @(posedge clk);
    do_start(2'd3);
    wait_done(400, 258, "restart");
    chk("restart55", 768'(num_arr_hard[5][5]), 768'(7));

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
